// File: rtl/data_memory_access_unit.sv
// data_memory_access_unit: MEM-stage initiator turning one load/store request into a single data memory transaction.
module data_memory_access_unit #(
  parameter int MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic        reqWord,
  input  logic        reqSigned,
  input  logic [15:0] reqAddress,
  input  logic [15:0] reqData,
  output logic        rspValid,
  output logic [15:0] rspData,
  output logic        rspFault,
  output logic        stall,
  output logic        memWrEnable,
  output logic        memRdEnable,
  output logic [1:0]  memNumberOfByte,
  output logic [15:0] memAddress,
  output logic [15:0] memIn,
  input  logic [15:0] memOut
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  state_t      state_q, state_d;
  logic        wr_q, wr_d, fault_q, fault_d;
  logic [1:0]  nob_q, nob_d;
  logic [15:0] addr_q, addr_d, din_q, din_d, rdata_q, rdata_d;
  logic        accept, fault;
  assign accept = (state_q == IDLE) && reqValid;
  // 17-bit sum so a word access at 0xFFFF faults rather than wrapping to 0
  assign fault  = ({1'b0, reqAddress} + {16'd0, reqWord}) >= 17'(MEM_BYTES);
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    fault_d = fault_q;
    nob_d   = nob_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE:    state_d = reqValid ? (fault ? RESP : ISSUE) : IDLE;
      ISSUE:   state_d = wr_q ? RESP : CAPTURE;
      CAPTURE: state_d = RESP;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      wr_d    = reqWrite;
      fault_d = fault;
      rdata_d = '0;
    end
    if (accept && !fault) begin
      addr_d = reqAddress;
      nob_d  = reqWrite ? (reqWord ? 2'b10 : 2'b01) : (reqWord ? 2'b00 : (reqSigned ? 2'b10 : 2'b01));
      din_d  = reqWrite ? (reqWord ? reqData : {8'h00, reqData[7:0]}) : din_q;
    end
    if (state_q == CAPTURE) rdata_d = memOut;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      fault_q <= 1'b0;
      nob_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      fault_q <= fault_d;
      nob_q   <= nob_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
    end
  end
  assign reqReady        = state_q == IDLE;
  assign stall           = reqValid & ~reqReady;
  assign rspValid        = state_q == RESP;
  assign rspFault        = rspValid & fault_q;
  assign rspData         = rdata_q;
  assign memWrEnable     = (state_q == ISSUE) & wr_q;
  assign memRdEnable     = (state_q == ISSUE) & ~wr_q;
  assign memNumberOfByte = nob_q;
  assign memAddress      = addr_q;
  assign memIn           = din_q;
endmodule
